// File: rtl/chunked_add_seq.sv
// Sequential WIDTH*CHUNKS-bit adder: one WIDTH-bit chunk per cycle, LSB first, carry registered between chunks.
// Latency start->done is CHUNKS cycles (1..CHUNKS with CHUNKED_ADD_ZERO_SKIP_EN defined); one add per CHUNKS+1 cycles.
// No backpressure: start is sampled only while idle; a start while busy is dropped, not queued.
module chunked_add_seq #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH*CHUNKS-1:0] a,
    input  logic [WIDTH*CHUNKS-1:0] b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH*CHUNKS-1:0] sum,
    output logic                    carry_out
);
    localparam int OPW = WIDTH * CHUNKS;
    localparam int KW  = $clog2(CHUNKS);
    localparam logic [KW-1:0] LAST = KW'(CHUNKS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, next_state;
    logic [OPW-1:0]   a_reg, b_reg, work_sum, work_next;
    logic             carry_reg;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_chunk, b_chunk;
    logic [WIDTH:0]   slice;
    logic             skip_ok, finish;

    always_comb begin
        next_state = state;
        a_chunk    = a_reg[k*WIDTH +: WIDTH];
        b_chunk    = b_reg[k*WIDTH +: WIDTH];
        slice      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{WIDTH{1'b0}}, carry_reg};
        work_next  = work_sum;
        work_next[k*WIDTH +: WIDTH] = slice[WIDTH-1:0];
`ifdef CHUNKED_ADD_ZERO_SKIP_EN
        // Nothing left above chunk k and no carry: the upper result chunks are already zero.
        skip_ok    = !slice[WIDTH] && (((a_reg | b_reg) >> ((int'(k) + 1) * WIDTH)) == '0);
`else
        skip_ok    = 1'b0;
`endif
        finish     = (state == RUN) && ((k == LAST) || skip_ok);
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (finish) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            work_sum  <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_reg     <= a;
                    b_reg     <= b;
                    carry_reg <= cin;
                    k         <= '0;
                    work_sum  <= '0;
                end
            end else begin
                work_sum  <= work_next;
                carry_reg <= slice[WIDTH];
                k         <= k + KW'(1);
                if (finish) begin
                    sum       <= work_next;
                    carry_out <= slice[WIDTH];
                    done      <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_chunked_add_seq.sv
// Directed bench for chunked_add_seq at WIDTH=4, CHUNKS=4; latency expectations follow CHUNKED_ADD_ZERO_SKIP_EN.
module tb_chunked_add_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic        busy, done, carry_out;
    logic [15:0] sum;

    int tests_run = 0;
    int tests_failed = 0;

    chunked_add_seq #(.WIDTH(4), .CHUNKS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Start one addition, wait (bounded) for done, then check result, latency and the done pulse width.
    task automatic run_add(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic tcin, input logic [15:0] es, input logic eco,
                           input int elat, input logic [15:0] prev);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        while (!seen && n < 20) begin
            @(posedge clk);
            #1 n++;
            if (done) seen = 1;
            else check({tag, "_sum_hold"}, sum, prev);
        end
        check({tag, "_latency"}, n, elat);
        check({tag, "_sum"}, sum, es);
        check({tag, "_carry_out"}, carry_out, eco);
        check({tag, "_busy_done"}, busy, 0);
        @(posedge clk);
        #1 check({tag, "_done_pulse"}, done, 0);
    endtask

`ifdef CHUNKED_ADD_ZERO_SKIP_EN
    localparam int LAT_SMALL = 1;
    localparam int LAT_CIN   = 2;
`else
    localparam int LAT_SMALL = 4;
    localparam int LAT_CIN   = 4;
`endif

    initial begin
        bit seen_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_carry_out", carry_out, 0);
        rst = 1'b0;

        run_add("small",   16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, LAT_SMALL, 16'h0000);
        run_add("ovf",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4, 16'h0003);
        run_add("ripple",  16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 4, 16'h0000);
        run_add("cin",     16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, LAT_CIN, 16'h0000);

        // Starts at the cycle after acceptance and on the completion edge must be dropped.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ign_busy_e0", busy, 1);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ign_busy_e1", busy, 1);
        check("ign_sum_hold", sum, 16'h0010);
        @(posedge clk);
        @(posedge clk);
        #1 check("ign_done_e3", done, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ign_done_e4", done, 1);
        check("ign_sum_e4", sum, 16'h2345);
        check("ign_co_e4", carry_out, 0);
        @(posedge clk);
        #1;
        check("ign_busy_e5", busy, 0);
        check("ign_done_e5", done, 0);
        check("ign_sum_e5", sum, 16'h2345);
        run_add("after",   16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 4, 16'h2345);

        // Reset mid-run aborts without a done pulse.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_carry_out", carry_out, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        seen_done = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
